// File: rtl/xor_lfsr_gen.sv
// Parametrised Galois LFSR with free-run PRBS and serial data-in (CRC/scrambler) modes.
// Optional all-zero lockup recovery enabled by defining LFSR_LOCKUP_RECOVER_EN.
module xor_lfsr_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  input  logic             din,
  output logic [WIDTH-1:0] state,
  output logic             dout,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_at_seed;

  // Galois right-shift step; din only enters the feedback in data-in mode
  assign w_fb      = r_state[0] ^ (mode & din);
  assign w_next    = (r_state >> 1) ^ (w_fb ? TAPS : '0);
  assign w_at_seed = (w_next == SEED);

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic r_lockup;
  logic w_stuck;

  assign w_stuck = (r_state == '0) && !mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SEED;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else if (load) begin
      r_state  <= seed_in;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else if (en) begin
      if (w_stuck) begin
        // Free-run from all-zero would never leave; restart the sequence instead
        r_state  <= SEED;
        r_cnt    <= '0;
        r_wrap   <= 1'b0;
        r_lockup <= 1'b1;
      end else begin
        r_state  <= w_next;
        r_cnt    <= w_at_seed ? '0 : r_cnt + WIDTH'(1);
        r_wrap   <= w_at_seed;
        r_lockup <= 1'b0;
      end
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end
  end

  assign lockup = r_lockup;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_state <= seed_in;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      r_cnt   <= w_at_seed ? '0 : r_cnt + WIDTH'(1);
      r_wrap  <= w_at_seed;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign lockup = 1'b0;
`endif

  assign state = r_state;
  assign dout  = r_state[0];
  assign cnt   = r_cnt;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_xor_lfsr_gen.sv
// Self-checking bench for xor_lfsr_gen (default WIDTH=8, TAPS=B8, SEED=01).
module tb_xor_lfsr_gen;

  localparam int TAPS_I = 'hB8;
  localparam int SEED_I = 'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       mode = 1'b0;
  logic       din = 1'b0;
  logic [7:0] state;
  logic       dout;
  logic [7:0] cnt;
  logic       wrap;
  logic       lockup;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept as plain integers
  int m_state = SEED_I;
  int m_cnt   = 0;
  int m_wrap  = 0;
  int m_lock  = 0;

  bit seen [256];

  xor_lfsr_gen dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .seed_in (seed_in),
    .mode    (mode),
    .din     (din),
    .state   (state),
    .dout    (dout),
    .cnt     (cnt),
    .wrap    (wrap),
    .lockup  (lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the behavioural rules
  task automatic model_edge(input int r, input int l, input int e, input int md, input int dn,
                            input int sd);
    int fb;
    int nx;
    if (r != 0) begin
      m_state = SEED_I; m_cnt = 0; m_wrap = 0; m_lock = 0;
    end else if (l != 0) begin
      m_state = sd; m_cnt = 0; m_wrap = 0; m_lock = 0;
    end else if (e != 0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (m_state == 0 && md == 0) begin
        m_state = SEED_I; m_cnt = 0; m_wrap = 0; m_lock = 1;
        return;
      end
`endif
      fb = (m_state % 2) ^ ((md != 0) ? dn : 0);
      nx = (m_state / 2) ^ ((fb != 0) ? TAPS_I : 0);
      if (nx == SEED_I) begin
        m_cnt = 0; m_wrap = 1;
      end else begin
        m_cnt = (m_cnt + 1) % 256; m_wrap = 0;
      end
      m_state = nx;
      m_lock  = 0;
    end else begin
      m_wrap = 0; m_lock = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  state,        8'(m_state));
    chk({tag, ".dout"},   {7'd0, dout}, 8'(m_state % 2));
    chk({tag, ".cnt"},    cnt,          8'(m_cnt));
    chk({tag, ".wrap"},   {7'd0, wrap}, 8'(m_wrap));
    chk({tag, ".lockup"}, {7'd0, lockup}, 8'(m_lock));
  endtask

  task automatic cycle(input string tag, input logic r, input logic l, input logic e,
                       input logic md, input logic dn, input logic [7:0] sd);
    @(negedge clk);
    rst = r; load = l; en = e; mode = md; din = dn; seed_in = sd;
    model_edge(int'(r), int'(l), int'(e), int'(md), int'(dn), int'(sd));
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin : stim
    logic [7:0] exp_seq [6];
    logic [7:0] exp_dout;
    exp_seq[0] = 8'h01; exp_seq[1] = 8'hB8; exp_seq[2] = 8'h5C;
    exp_seq[3] = 8'h2E; exp_seq[4] = 8'h17; exp_seq[5] = 8'hB3;
    exp_dout = 8'b0011_0001;

    // Reset and first free-run steps against the published sequence
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset.const_state", state, 8'h01);
    chk("reset.const_cnt", cnt, 8'h00);
    for (int i = 1; i < 6; i++) begin
      cycle("freerun", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("freerun.const_state", state, exp_seq[i]);
      chk("freerun.const_dout", {7'd0, dout}, {7'd0, exp_dout[i]});
      chk("freerun.const_cnt", cnt, 8'(i));
    end

    // Full maximal-length period
    cycle("period_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      cycle("period", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("period.distinct", {7'd0, seen[state]}, 8'h00);
      chk("period.nonzero", {7'd0, (state == 8'h00)}, 8'h00);
      seen[state] = 1'b1;
      if (i == 254) chk("period.cnt254", cnt, 8'd254);
      if (i < 255) chk("period.nowrap", {7'd0, wrap}, 8'h00);
    end
    chk("period.wrap", {7'd0, wrap}, 8'h01);
    chk("period.seed", state, 8'h01);
    chk("period.cnt0", cnt, 8'h00);
    cycle("period_after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("period.wrap_drop", {7'd0, wrap}, 8'h00);

    // Load beats en in the same cycle
    cycle("ld_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("ld_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("ld_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("ld.pre_state", state, 8'h5C);
    cycle("ld", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    chk("ld.const_state", state, 8'hA5);
    chk("ld.const_cnt", cnt, 8'h00);
    cycle("ld_step", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("ld.const_next", state, 8'hEA);

    // Data-in folding into all-zero, then free-run from zero
    cycle("din_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("din", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    chk("din.const_zero", state, 8'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
    cycle("recover", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("recover.state", state, 8'h01);
    chk("recover.cnt", cnt, 8'h00);
    chk("recover.lockup", {7'd0, lockup}, 8'h01);
    chk("recover.wrap", {7'd0, wrap}, 8'h00);
    cycle("recover_after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("recover.lockup_drop", {7'd0, lockup}, 8'h00);
`else
    for (int i = 0; i < 3; i++) begin
      cycle("zero_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("zero_hold.state", state, 8'h00);
      chk("zero_hold.lockup", {7'd0, lockup}, 8'h00);
    end
`endif
    // Zero seed loads zero
    cycle("ld_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ld_zero.state", state, 8'h00);

    // Reset mid-operation wins over load and en, then idle hold
    cycle("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++)
      cycle("mid_step", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    chk("mid.const_state", state, 8'h01);
    chk("mid.const_cnt", cnt, 8'h00);
    chk("mid.const_wrap", {7'd0, wrap}, 8'h00);
    cycle("idle_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("idle_pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("idle.const_state", state, 8'h5C);
      chk("idle.const_cnt", cnt, 8'h02);
    end

    // Randomized mix of every control against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, l, e, md, dn;
      logic [7:0] sd;
      r  = ($urandom_range(0, 63) == 0);
      l  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = ($urandom_range(0, 3) == 0);
      dn = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle("rand", r, l, e, md, dn, sd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
